// File: rtl/effect_chain_scheduler.sv
// Walks one sample through N_EFFECTS chained effect slots using the cs/my_turn/done handshake.
// Optional per-stage watchdog enabled by defining SCHED_TIMEOUT_EN.
module effect_chain_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int N_EFFECTS  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sample_valid,
  input  logic [DATA_WIDTH-1:0]           sample_in,
  input  logic [N_EFFECTS-1:0]            bypass,
  output logic [N_EFFECTS-1:0]            cs,
  output logic [N_EFFECTS-1:0]            my_turn,
  output logic [DATA_WIDTH-1:0]           stage_data_out,
  input  logic [N_EFFECTS-1:0]            stage_done,
  input  logic [N_EFFECTS*DATA_WIDTH-1:0] stage_data_in,
  output logic [DATA_WIDTH-1:0]           sample_out,
  output logic                            sample_out_valid,
  output logic                            busy,
  output logic                            overrun,
  output logic                            timeout
);

  localparam int IW = $clog2(N_EFFECTS + 1);
  localparam int PW = 1 << IW;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_WAIT, S_OUT} state_t;

  state_t                  state_q;
  logic [IW-1:0]           idx_q;
  logic [DATA_WIDTH-1:0]   cur_q;
  logic [DATA_WIDTH-1:0]   sample_out_q;
  logic                    overrun_q;

  // Per-stage vectors padded to a power of two so idx_q can index them directly.
  logic [PW-1:0]           byp_pad;
  logic [PW-1:0]           done_pad;
  logic [DATA_WIDTH-1:0]   res [PW];

  assign byp_pad  = {{(PW-N_EFFECTS){1'b0}}, bypass};
  assign done_pad = {{(PW-N_EFFECTS){1'b0}}, stage_done};

  for (genvar g = 0; g < PW; g++) begin : g_res
    if (g < N_EFFECTS) begin : g_real
      assign res[g] = stage_data_in[g*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign res[g] = '0;
    end
  end

  for (genvar g = 0; g < N_EFFECTS; g++) begin : g_grant
    assign my_turn[g] = (state_q == S_WAIT) && (idx_q == IW'(g));
  end

  assign cs               = my_turn;
  assign stage_data_out   = cur_q;
  assign sample_out       = sample_out_q;
  assign sample_out_valid = (state_q == S_OUT);
  assign busy             = (state_q == S_SELECT) || (state_q == S_WAIT);
  assign overrun          = overrun_q;

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TW-1:0] wdog_q;
  logic          timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cur_q        <= '0;
      sample_out_q <= '0;
      overrun_q    <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      // A sample offered while the chain is working is dropped and flagged.
      overrun_q <= sample_valid && ((state_q == S_SELECT) || (state_q == S_WAIT));
`ifdef SCHED_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE, S_OUT: begin
          if (sample_valid) begin
            cur_q   <= sample_in;
            idx_q   <= '0;
            state_q <= S_SELECT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SELECT: begin
          if (idx_q == IW'(N_EFFECTS)) begin
            sample_out_q <= cur_q;
            state_q      <= S_OUT;
          end else if (byp_pad[idx_q]) begin
            idx_q <= idx_q + IW'(1);
          end else begin
            state_q <= S_WAIT;
`ifdef SCHED_TIMEOUT_EN
            wdog_q  <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (done_pad[idx_q]) begin
            cur_q   <= res[idx_q];
            idx_q   <= idx_q + IW'(1);
            state_q <= S_SELECT;
          end
`ifdef SCHED_TIMEOUT_EN
          // Abandon a stuck stage; the running sample passes through unchanged.
          else if (wdog_q == TW'(TIMEOUT - 1)) begin
            idx_q     <= idx_q + IW'(1);
            state_q   <= S_SELECT;
            timeout_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + TW'(1);
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
